// File: rtl/coin_pkg.sv
// coin_pkg: shared constants for the coin controller.
//   - Coin values selected by SW[3:0] (penny, nickel, dime, quarter).
//   - Default saturation ceiling of the cents balance.
//   - Active-low 7-segment table, bit order {dp, g, f, e, d, c, b, a}.
//     The dp bit is held at 1 (off). Codes 10..15 are blank.
package coin_pkg;

  localparam logic [6:0] V_PENNY   = 7'd1;
  localparam logic [6:0] V_NICKEL  = 7'd5;
  localparam logic [6:0] V_DIME    = 7'd10;
  localparam logic [6:0] V_QUARTER = 7'd25;

  localparam int unsigned MAX_BAL_DEF = 99;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: one decimal digit to an active-low 7-segment pattern.
// Ports:
//   digit   in  4  BCD digit (10..15 give a blank pattern)
//   pattern out 8  {dp, g..a}, active-low, dp always 1 (off)
module seg7_dec
  import coin_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] pattern
);

  assign pattern = SEG_TABLE[digit];

endmodule

// File: rtl/coin_controller.sv
// coin_controller: coin-accumulating front end for a vending machine.
// Each falling edge of KEY[1] adds the switch-selected coin value to a
// balance that saturates at MAX_BAL. Balance and coin value are shown on
// the 7-segment displays; LEDR shows FULL, an accept pulse and SW[3:0].
// Ports:
//   KEY     in  2   KEY[0] async active-low reset, KEY[1] active-low coin strobe
//   SW      in  10  SW[3:0] coin select, SW[9:4] unused
//   clock   in  1   system clock, rising edge
//   LEDR    out 10  [9:5] FULL bar, [4] coin-accepted pulse, [3:0] SW[3:0]
//   HEX0    out 8   balance ones digit (active-low, dp off)
//   HEX1    out 8   balance tens digit
//   HEX4    out 8   coin value ones digit
//   HEX5    out 8   coin value tens digit
//   balance out 7   registered balance in cents
//   value   out 7   coin value decoded from SW (combinational)
// Build option: define COIN_SYNC_EN to pass KEY[1] through a 2-flop
// synchronizer before edge detection (accept is then 2 cycles later).
module coin_controller
  import coin_pkg::*;
#(
  parameter int unsigned MAX_BAL = MAX_BAL_DEF
) (
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  input  logic       clock,
  output logic [9:0] LEDR,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [6:0] balance,
  output logic [6:0] value
);

  localparam logic [6:0] MAX7 = 7'(MAX_BAL);

  logic       rst_n;
  logic       key_in;
  logic       k_q;
  logic       armed;
  logic       accept;
  logic       acc_q;
  logic       full;
  logic [7:0] sum;
  logic [6:0] bal_next;
  logic [3:0] bal_tens;
  logic [3:0] bal_ones;
  logic [3:0] val_tens;
  logic [3:0] val_ones;
  logic       unused_sw;

  assign rst_n     = KEY[0];
  assign unused_sw = ^SW[9:4];

  // Coin select, highest-value switch wins.
  always_comb begin
    value = 7'd0;
    if (SW[3])      value = V_QUARTER;
    else if (SW[2]) value = V_DIME;
    else if (SW[1]) value = V_NICKEL;
    else if (SW[0]) value = V_PENNY;
  end

`ifdef COIN_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], KEY[1]};
  end

  assign key_in = sync_q[1];
`else
  assign key_in = KEY[1];
`endif

  // armed stays low after reset until the strobe is seen released, so a
  // key held through reset does not produce a deposit.
  assign accept = armed && k_q && !key_in;

  // 8-bit sum so that balance + value can never wrap before saturation.
  assign sum      = {1'b0, balance} + {1'b0, value};
  assign bal_next = !accept          ? balance :
                    (sum >= {1'b0, MAX7}) ? MAX7 : sum[6:0];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= 1'b1;
      armed   <= 1'b0;
      acc_q   <= 1'b0;
      balance <= 7'd0;
      full    <= 1'b0;
    end else begin
      k_q     <= key_in;
      armed   <= armed | key_in;
      acc_q   <= accept;
      balance <= bal_next;
      full    <= (bal_next == MAX7);
    end
  end

  assign LEDR = {{5{full}}, acc_q, SW[3:0]};

  assign bal_tens = 4'(balance / 7'd10);
  assign bal_ones = 4'(balance % 7'd10);
  assign val_tens = 4'(value / 7'd10);
  assign val_ones = 4'(value % 7'd10);

  seg7_dec u_hex0 (.digit(bal_ones), .pattern(HEX0));
  seg7_dec u_hex1 (.digit(bal_tens), .pattern(HEX1));
  seg7_dec u_hex4 (.digit(val_ones), .pattern(HEX4));
  seg7_dec u_hex5 (.digit(val_tens), .pattern(HEX5));

endmodule

// File: tb/tb_coin_controller.sv
module tb_coin_controller;

  logic [1:0] KEY;
  logic [9:0] SW;
  logic       clock;
  logic [9:0] LEDR;
  logic [7:0] HEX0, HEX1, HEX4, HEX5;
  logic [6:0] balance, value;

  int vectors = 0;
  int miscompares = 0;

  coin_controller dut (
    .KEY(KEY), .SW(SW), .clock(clock), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX4(HEX4), .HEX5(HEX5),
    .balance(balance), .value(value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold KEY[1] low for 'hold' cycles, release, let it settle; report how
  // many cycles LEDR[4] was seen high over the whole press.
  task automatic press(input int hold, output int pulses);
    pulses = 0;
    KEY[1] = 1'b0;
    repeat (hold) begin
      tick();
      if (LEDR[4]) pulses++;
    end
    KEY[1] = 1'b1;
    repeat (4) begin
      tick();
      if (LEDR[4]) pulses++;
    end
  endtask

  task automatic do_reset();
    KEY = 2'b10;
    repeat (2) tick();
    KEY[0] = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int p;
    logic [6:0] exp_bal [8];
    exp_bal = '{7'd25, 7'd50, 7'd75, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99};

    KEY = 2'b10;
    SW  = 10'd0;
    tick();
    tick();

    // 1: reset state
    check("rst_balance", 32'(balance), 32'd0);
    check("rst_hex0", 32'(HEX0), 32'hC0);
    check("rst_hex1", 32'(HEX1), 32'hC0);
    check("rst_full", 32'(LEDR[9:5]), 32'd0);
    check("rst_pulse", 32'(LEDR[4]), 32'd0);
    KEY[0] = 1'b1;
    repeat (2) tick();
    check("post_rst_balance", 32'(balance), 32'd0);

    // 2: quarters up to saturation
    SW = 10'b00_0000_1000;
    #1;
    check("val_quarter", 32'(value), 32'd25);
    for (int i = 0; i < 8; i++) begin
      press(4, p);
      check($sformatf("q_bal_%0d", i), 32'(balance), 32'(exp_bal[i]));
      check($sformatf("q_full_%0d", i), 32'(LEDR[9:5]), (i >= 3) ? 32'h1F : 32'h0);
      check($sformatf("q_pulse_%0d", i), 32'(p), 32'd1);
    end
    check("led_mirror_q", 32'(LEDR[3:0]), 32'h8);

    // 3: one long press counts once
    do_reset();
    check("rst2_balance", 32'(balance), 32'd0);
    SW = 10'b00_0000_0100;
    press(20, p);
    check("long_bal", 32'(balance), 32'd10);
    check("long_pulse", 32'(p), 32'd1);
    check("long_full", 32'(LEDR[9:5]), 32'd0);

    // 4: priority decode and zero-value press
    SW = 10'b00_0000_1111;
    #1;
    check("val_1111", 32'(value), 32'd25);
    SW = 10'b00_0000_0011;
    #1;
    check("val_0011", 32'(value), 32'd5);
    SW = 10'b11_1111_0000;
    #1;
    check("val_none", 32'(value), 32'd0);
    press(4, p);
    check("zero_bal", 32'(balance), 32'd10);
    check("zero_pulse", 32'(p), 32'd1);

    // 5: build balance 37 and check displays
    SW = 10'b00_0000_1000;
    press(4, p);
    SW = 10'b00_0000_0001;
    press(4, p);
    press(5, p);
    check("bal37", 32'(balance), 32'd37);
    check("hex1_3", 32'(HEX1), 32'hB0);
    check("hex0_7", 32'(HEX0), 32'hF8);
    SW = 10'b00_0000_0010;
    #1;
    check("hex5_0", 32'(HEX5), 32'hC0);
    check("hex4_5", 32'(HEX4), 32'h92);
    check("led_mirror_n", 32'(LEDR[3:0]), 32'h2);

    // 6: reset while the strobe is held low
    KEY[1] = 1'b0;
    repeat (6) tick();
    check("held_bal", 32'(balance), 32'd42);
    KEY[0] = 1'b0;
    #1;
    check("async_clear", 32'(balance), 32'd0);
    check("async_pulse", 32'(LEDR[4]), 32'd0);
    tick();
    KEY[0] = 1'b1;
    p = 0;
    repeat (8) begin
      tick();
      if (LEDR[4]) p++;
    end
    check("held_no_dep_bal", 32'(balance), 32'd0);
    check("held_no_dep_pulse", 32'(p), 32'd0);
    KEY[1] = 1'b1;
    repeat (4) tick();
    check("released_bal", 32'(balance), 32'd0);
    press(4, p);
    check("rearm_bal", 32'(balance), 32'd5);
    check("rearm_pulse", 32'(p), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
